resp_frame_generator: RTL and testbench
=======================================

# resp_frame_generator

Multi-channel, parametrised successor to the single-channel ACK/NAK generator. Up to NUM_CH requesters post ACK or NAK responses tagged with an event ID. Each channel has a one-entry holding slot, and a round-robin arbiter picks the next channel. A single framing engine serialises each response onto the message byte stream with back-pressure. The block sits between the protocol decoders and the outbound message mux.

## Interface
Parameters:
- NUM_CH, 4: number of requesting channels (1..16).
- DATA_W, 8: message word width; also the width of EID and status.
- STATUS_EN, 0: 1 appends a status word and sets the length field to 1.

Ports:
- clk  in  1  block clock; the only clock.
- reset  in  1  synchronous, active-high.
- generate_ack  in  NUM_CH  per-channel ACK request pulse.
- generate_nak  in  NUM_CH  per-channel NAK request pulse.
- eid_in  in  NUM_CH*DATA_W  per-channel event ID; channel c uses bits [c*DATA_W +: DATA_W].
- status_in  in  NUM_CH*DATA_W  per-channel status; same slicing; ignored when STATUS_EN=0.
- message_wait  in  1  sink stall; holds the current word.
- message_data  out  DATA_W  current frame word.
- message_data_valid  out  1  message_data is valid.
- message_frame_valid  out  1  high for the whole frame.
- message_ch  out  $clog2(NUM_CH) (min 1)  channel index of the current frame.
- slot_busy  out  NUM_CH  channel slot holds an unsent response.
- req_drop  out  NUM_CH  1-cycle pulse: request rejected because the slot was busy.

## Operation
- Request capture: any of ack[c] or nak[c] high at an edge with slot c free captures type, eid and status into slot c.
  - NAK wins if ack and nak are both high.
  - eid and status are sampled on the request cycle only.
- Busy slot: a request to a busy slot is dropped. req_drop[c]=1 in the next cycle; slot contents are unchanged.
- Slot release: a slot is freed at the edge its frame starts. It may accept a new request while its frame is still transmitting.
- Arbitration: round-robin over candidates. A candidate is a busy slot, or a same-cycle incoming request on a free slot (bypass).
  - The pointer advances to the winner+1 on each grant.
  - Reset pointer = 0.
- Frame words, in order:
  - TYPE = 0 for ACK, 1 for NAK (zero-extended).
  - EID = eid.
  - LEN = STATUS_EN ? 1 : 0.
  - STAT = status, only if STATUS_EN.
- States: IDLE -> TYPE -> EID -> LEN -> (STAT) -> GAP -> IDLE or TYPE.
  - A word advances only at an edge with message_wait=0.
  - GAP lasts exactly one cycle with both valids low and message_data=0. It is never stretched or skipped.
- Reset: clears all slots, drops and the pointer, and forces IDLE, including mid-frame.
  - Every output reads 0 in the cycle after reset is sampled. This covers message_data, both valids, message_ch, slot_busy and req_drop.
  - A frame interrupted by reset is never resumed.

## Timing
- Request at edge k with the engine idle -> TYPE word on the outputs from edge k (visible in cycle k+1). Latency is 1 cycle.
- All outputs are registered. No combinational path from inputs to outputs.
- message_wait high holds data, valids and message_ch stable. Wait has no effect outside a frame.
  - Wait may be high at the grant edge; TYPE still appears and is held.
- Frame length with no stall: 3 words (STATUS_EN=0) or 4 words, plus 1 GAP cycle.
  - Back-to-back frame period: 4 or 5 cycles.
- Last word accepted at edge e -> GAP in cycle e+1 -> next TYPE from edge e+1 at the earliest.
  - The grant is decided at the GAP edge.
- slot_busy[c] rises the cycle after capture and falls the cycle after grant.
  - A bypass grant never raises slot_busy.

## Structure
- Package resp_frame_pkg holds:
  - state enum {IDLE, TYPE, EID, LEN, STAT, GAP};
  - TYPE_ACK=0 and TYPE_NAK=1;
  - LEN_NONE=0 and LEN_STATUS=1.
- Sub-module rr_arbiter #(N): request vector in, one-hot grant plus index out; pointer update on grant enable.
- The top level holds the slots, framing FSM and output registers.

## Test plan
- NUM_CH=1, STATUS_EN=0, ack[0] with eid=0x01 -> next cycle frame_valid=1 with 0x00, 0x01, 0x00 on consecutive cycles, then both valids 0.
- Same, nak[0] with eid=0x01 -> 0x01, 0x01, 0x00, then both valids 0.
- message_wait=1 with ack, held 8 cycles -> 0x00 held with valids=1 throughout. Wait released -> 0x01, then 0x00, then valids 0.
- NUM_CH=4, ack on ch0..ch3 in the same cycle with eid=0x10+c -> four frames with message_ch 0,1,2,3, 1-cycle gaps between them, frame period 4 cycles.
- Second request to ch2 while slot_busy[2]=1 -> req_drop[2] pulses; only one ch2 frame is sent. A request on both ack and nak -> TYPE=0x01.
- STATUS_EN=1, nak ch1 with eid=0x22 and status=0x5A -> frame 0x01, 0x22, 0x01, 0x5A.
- Reset asserted during the EID word -> the next cycle shows all outputs 0 and slot_busy=0, and the frame is never resumed.

Source files
------------

// File: rtl/resp_frame_generator_pkg.sv
// Shared types and constants for the multi-channel ACK/NAK response framer.
package resp_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TYPE,
        EID,
        LEN,
        STAT,
        GAP
    } state_e;

    localparam logic TYPE_ACK = 1'b0;
    localparam logic TYPE_NAK = 1'b1;

    localparam int LEN_NONE   = 0;
    localparam int LEN_STATUS = 1;

endpackage

// File: rtl/resp_frame_generator_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and index, pointer moves past the winner on each enabled grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;
    int            pos;

    assign any = |req;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr_q) + i;
            if (pos >= N) pos = pos - N;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos[IW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en && any) ptr_d = (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/resp_frame_generator.sv
// Multi-channel ACK/NAK response framer: per-channel holding slots, round-robin
// selection and a single framing engine driving the outbound message stream.
module resp_frame_generator
    import resp_frame_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int STATUS_EN = 0
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_CH-1:0]                          generate_ack,
    input  logic [NUM_CH-1:0]                          generate_nak,
    input  logic [NUM_CH*DATA_W-1:0]                   eid_in,
    input  logic [NUM_CH*DATA_W-1:0]                   status_in,
    input  logic                                       message_wait,
    output logic [DATA_W-1:0]                          message_data,
    output logic                                       message_data_valid,
    output logic                                       message_frame_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] message_ch,
    output logic [NUM_CH-1:0]                          slot_busy,
    output logic [NUM_CH-1:0]                          req_drop
);

    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   req, cap, gnt, grant_vec;
    logic [NUM_CH-1:0]   busy_q, busy_d, drop_q, drop_d;
    logic [NUM_CH-1:0]   typ_q;
    logic [DATA_W-1:0]   eid_q  [NUM_CH];
    logic [DATA_W-1:0]   stat_q [NUM_CH];
    logic [CHW-1:0]      win;
    logic                any_cand, grant;

    logic                f_type_q, f_type_d;
    logic [DATA_W-1:0]   f_eid_q, f_eid_d, f_stat_q, f_stat_d;
    logic [CHW-1:0]      f_ch_q, f_ch_d;

    logic [DATA_W-1:0]   data_q, data_d;
    logic                vld_q, vld_d;
    logic [CHW-1:0]      ch_q, ch_d;

    assign req       = generate_ack | generate_nak;
    assign grant     = ((state_q == IDLE) || (state_q == GAP)) && any_cand;
    assign grant_vec = grant ? gnt : '0;

    // Busy slots compete alongside fresh requests on free slots (bypass).
    rr_arbiter #(.N(NUM_CH), .IW(CHW)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (busy_q | req),
        .en    (grant),
        .gnt   (gnt),
        .idx   (win),
        .any   (any_cand)
    );

    assign cap    = req & ~busy_q & ~grant_vec;
    assign busy_d = (busy_q & ~grant_vec) | cap;
    assign drop_d = req & busy_q;

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (cap[c]) begin
                typ_q[c]  <= generate_nak[c] ? TYPE_NAK : TYPE_ACK;
                eid_q[c]  <= eid_in[c*DATA_W +: DATA_W];
                stat_q[c] <= status_in[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        f_type_d = f_type_q;
        f_eid_d  = f_eid_q;
        f_stat_d = f_stat_q;
        f_ch_d   = f_ch_q;
        if (grant) begin
            f_ch_d = win;
            if (busy_q[win]) begin
                f_type_d = typ_q[win];
                f_eid_d  = eid_q[win];
                f_stat_d = stat_q[win];
            end else begin
                f_type_d = generate_nak[win] ? TYPE_NAK : TYPE_ACK;
                f_eid_d  = eid_in[win*DATA_W +: DATA_W];
                f_stat_d = status_in[win*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = TYPE;
            TYPE:    if (!message_wait) state_d = EID;
            EID:     if (!message_wait) state_d = LEN;
            LEN:     if (!message_wait) state_d = (STATUS_EN != 0) ? STAT : GAP;
            STAT:    if (!message_wait) state_d = GAP;
            GAP:     state_d = grant ? TYPE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        data_d = '0;
        case (state_d)
            TYPE:    data_d = DATA_W'(f_type_d);
            EID:     data_d = f_eid_d;
            LEN:     data_d = (STATUS_EN != 0) ? DATA_W'(LEN_STATUS) : DATA_W'(LEN_NONE);
            STAT:    data_d = f_stat_d;
            default: data_d = '0;
        endcase
        vld_d = state_d inside {TYPE, EID, LEN, STAT};
        ch_d  = vld_d ? f_ch_d : '0;
    end

    always_ff @(posedge clk) begin
        f_type_q <= f_type_d;
        f_eid_q  <= f_eid_d;
        f_stat_q <= f_stat_d;
        f_ch_q   <= f_ch_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= '0;
            drop_q  <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            ch_q    <= ch_d;
        end
    end

    assign message_data        = data_q;
    assign message_data_valid  = vld_q;
    assign message_frame_valid = vld_q;
    assign message_ch          = ch_q;
    assign slot_busy           = busy_q;
    assign req_drop            = drop_q;

endmodule

// File: tb/tb_resp_frame_generator.sv
// Directed-vector bench for resp_frame_generator: a 4-channel plain instance and a 2-channel status instance.
module tb_resp_frame_generator;

    logic        clk = 1'b0;
    logic        reset;

    logic [3:0]  ack4, nak4;
    logic [31:0] eid4, st4;
    logic        wait4;
    logic [7:0]  data4;
    logic        dv4, fv4;
    logic [1:0]  ch4;
    logic [3:0]  busy4, drop4;

    logic [1:0]  ack2, nak2;
    logic [15:0] eid2, st2;
    logic        wait2;
    logic [7:0]  data2;
    logic        dv2, fv2;
    logic [0:0]  ch2;
    logic [1:0]  busy2, drop2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    resp_frame_generator #(.NUM_CH(4), .DATA_W(8), .STATUS_EN(0)) dut (
        .clk                 (clk),
        .reset               (reset),
        .generate_ack        (ack4),
        .generate_nak        (nak4),
        .eid_in              (eid4),
        .status_in           (st4),
        .message_wait        (wait4),
        .message_data        (data4),
        .message_data_valid  (dv4),
        .message_frame_valid (fv4),
        .message_ch          (ch4),
        .slot_busy           (busy4),
        .req_drop            (drop4)
    );

    resp_frame_generator #(.NUM_CH(2), .DATA_W(8), .STATUS_EN(1)) dut_s (
        .clk                 (clk),
        .reset               (reset),
        .generate_ack        (ack2),
        .generate_nak        (nak2),
        .eid_in              (eid2),
        .status_in           (st2),
        .message_wait        (wait2),
        .message_data        (data2),
        .message_data_valid  (dv2),
        .message_frame_valid (fv2),
        .message_ch          (ch2),
        .slot_busy           (busy2),
        .req_drop            (drop2)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        check_vec({tag, "_fv"}, 32'(fv4), 32'(v));
        check_vec({tag, "_dv"}, 32'(dv4), 32'(v));
        check_vec({tag, "_data"}, 32'(data4), 32'(d));
        check_vec({tag, "_ch"}, 32'(ch4), 32'(c));
    endtask

    task automatic chk2(input string tag, input logic v, input logic [7:0] d, input logic c);
        check_vec({tag, "_fv"}, 32'(fv2), 32'(v));
        check_vec({tag, "_dv"}, 32'(dv2), 32'(v));
        check_vec({tag, "_data"}, 32'(data2), 32'(d));
        check_vec({tag, "_ch"}, 32'(ch2), 32'(c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ack4 = '0; nak4 = '0; eid4 = '0; st4 = '0; wait4 = 1'b0;
        ack2 = '0; nak2 = '0; eid2 = '0; st2 = '0; wait2 = 1'b0;
        tick();
        tick();
        chk4("rst4", 1'b0, 8'h00, 2'd0);
        check_vec("rst4_busy", 32'(busy4), 32'h0);
        check_vec("rst4_drop", 32'(drop4), 32'h0);
        chk2("rst2", 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        tick();

        // ACK ch0, eid 0x01
        ack4 = 4'b0001; eid4[7:0] = 8'h01;
        tick();
        ack4 = '0;
        chk4("ack_type", 1'b1, 8'h00, 2'd0);
        check_vec("ack_bypass_busy", 32'(busy4), 32'h0);
        tick(); chk4("ack_eid", 1'b1, 8'h01, 2'd0);
        tick(); chk4("ack_len", 1'b1, 8'h00, 2'd0);
        tick(); chk4("ack_gap", 1'b0, 8'h00, 2'd0);
        tick(); chk4("ack_idle", 1'b0, 8'h00, 2'd0);

        // NAK ch0, eid 0x01
        nak4 = 4'b0001;
        tick();
        nak4 = '0;
        chk4("nak_type", 1'b1, 8'h01, 2'd0);
        tick(); chk4("nak_eid", 1'b1, 8'h01, 2'd0);
        tick(); chk4("nak_len", 1'b1, 8'h00, 2'd0);
        tick(); chk4("nak_gap", 1'b0, 8'h00, 2'd0);
        tick();

        // Wait high from the grant edge, held for 8 cycles
        ack4 = 4'b0001; wait4 = 1'b1;
        tick();
        ack4 = '0;
        chk4("wait_type", 1'b1, 8'h00, 2'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk4("wait_hold", 1'b1, 8'h00, 2'd0);
        end
        wait4 = 1'b0;
        tick(); chk4("wait_eid", 1'b1, 8'h01, 2'd0);
        tick(); chk4("wait_len", 1'b1, 8'h00, 2'd0);
        tick(); chk4("wait_gap", 1'b0, 8'h00, 2'd0);

        // Fresh pointer, then all four channels request together
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) eid4[8*c +: 8] = 8'h10 + 8'(c);
        ack4 = 4'b1111;
        tick();
        ack4 = '0;
        check_vec("rr_busy", 32'(busy4), 32'hE);
        for (int f = 0; f < 4; f++) begin
            chk4("rr_type", 1'b1, 8'h00, 2'(f));
            tick(); chk4("rr_eid", 1'b1, 8'h10 + 8'(f), 2'(f));
            tick(); chk4("rr_len", 1'b1, 8'h00, 2'(f));
            tick(); chk4("rr_gap", 1'b0, 8'h00, 2'd0);
            tick();
        end
        chk4("rr_idle", 1'b0, 8'h00, 2'd0);
        check_vec("rr_busy_end", 32'(busy4), 32'h0);

        // Drop on busy ch2, and ack+nak together on ch3
        eid4[15:8] = 8'h21; eid4[23:16] = 8'h22;
        ack4 = 4'b0110;
        tick();
        chk4("drp_type1", 1'b1, 8'h00, 2'd1);
        check_vec("drp_busy1", 32'(busy4), 32'h4);
        ack4 = 4'b1100; nak4 = 4'b1000;
        eid4[23:16] = 8'h99; eid4[31:24] = 8'h33;
        tick();
        ack4 = '0; nak4 = '0;
        chk4("drp_eid1", 1'b1, 8'h21, 2'd1);
        check_vec("drp_pulse", 32'(drop4), 32'h4);
        check_vec("drp_busy2", 32'(busy4), 32'hC);
        tick();
        check_vec("drp_clear", 32'(drop4), 32'h0);
        tick(); chk4("drp_gap1", 1'b0, 8'h00, 2'd0);
        tick(); chk4("drp_type2", 1'b1, 8'h00, 2'd2);
        check_vec("drp_busy3", 32'(busy4), 32'h8);
        tick(); chk4("drp_eid2", 1'b1, 8'h22, 2'd2);
        tick(); tick(); chk4("drp_gap2", 1'b0, 8'h00, 2'd0);
        tick(); chk4("both_type", 1'b1, 8'h01, 2'd3);
        tick(); chk4("both_eid", 1'b1, 8'h33, 2'd3);
        tick(); tick(); chk4("both_gap", 1'b0, 8'h00, 2'd0);
        tick(); chk4("drp_idle", 1'b0, 8'h00, 2'd0);
        check_vec("drp_busy_end", 32'(busy4), 32'h0);

        // Status-enabled instance: nak ch1, eid 0x22, status 0x5A
        nak2 = 2'b10; eid2[15:8] = 8'h22; st2[15:8] = 8'h5A;
        tick();
        nak2 = '0;
        chk2("st_type", 1'b1, 8'h01, 1'b1);
        tick(); chk2("st_eid", 1'b1, 8'h22, 1'b1);
        tick(); chk2("st_len", 1'b1, 8'h01, 1'b1);
        tick(); chk2("st_stat", 1'b1, 8'h5A, 1'b1);
        tick(); chk2("st_gap", 1'b0, 8'h00, 1'b0);

        // Reset during EID word
        eid4[7:0] = 8'h44; eid4[15:8] = 8'h45;
        ack4 = 4'b0011;
        tick();
        ack4 = '0;
        chk4("mr_type", 1'b1, 8'h00, 2'd0);
        check_vec("mr_busy", 32'(busy4), 32'h2);
        tick(); chk4("mr_eid", 1'b1, 8'h44, 2'd0);
        reset = 1'b1;
        tick();
        chk4("mr_rst", 1'b0, 8'h00, 2'd0);
        check_vec("mr_rst_busy", 32'(busy4), 32'h0);
        check_vec("mr_rst_drop", 32'(drop4), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_vec("mr_no_resume", 32'(fv4), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
